// File: rtl/dsp_unit_mc.sv
// ---------------------------------------------------------------------------
// dsp_unit_mc
//
// Multichannel audio DSP stage: a per-channel FIR filter followed by a
// per-channel level gain with saturation. A single time-shared MAC handles
// one tap per cycle, channel by channel. Optional modes: FIR bypass
// (filter_en=0) and mono downmix (mono=1). The output latency is constant.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   tick_in      sample tick (one-cycle pulse)
//   cfg_in       load cfg_reg_in and coef_in (accepted only while idle)
//   level_in     load level_reg_in (accepted only while idle)
//   clr_in       clear delay lines/outputs/overrun, abort computation
//   abuf_in      input samples, channel c at [c*DATA_W +: DATA_W]
//   coef_in      FIR coefficients Q1.(COEF_W-1), tap k at [k*COEF_W +: COEF_W]
//   level_reg_in per-channel unsigned gains, 1<<(GAIN_W-1) is unity
//   cfg_reg_in   bit0 filter_en, bit1 mono
//   dsp_out      processed samples, held between valid_out pulses
//   valid_out    one-cycle pulse when dsp_out has been updated
//   busy_out     computation in progress
//   overrun_out  sticky: a tick arrived while busy and was dropped
// ---------------------------------------------------------------------------
module dsp_unit_mc #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 24,
    parameter int TAPS     = 32,
    parameter int COEF_W   = 32,
    parameter int GAIN_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick_in,
    input  logic                         cfg_in,
    input  logic                         level_in,
    input  logic                         clr_in,
    input  logic [CHANNELS*DATA_W-1:0]   abuf_in,
    input  logic [TAPS*COEF_W-1:0]       coef_in,
    input  logic [CHANNELS*GAIN_W-1:0]   level_reg_in,
    input  logic [31:0]                  cfg_reg_in,
    output logic [CHANNELS*DATA_W-1:0]   dsp_out,
    output logic                         valid_out,
    output logic                         busy_out,
    output logic                         overrun_out
);

    localparam int KW     = $clog2(TAPS);
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;      // one MAC product
    localparam int ACC_W  = PROD_W + KW;          // full-precision accumulator
    localparam int F_W    = ACC_W - COEF_W + 1;   // filter result after >>> (COEF_W-1)
    localparam int SRC_W  = F_W + 1;              // room for the mono sum
    localparam int SP_W   = SRC_W + GAIN_W + 1;   // signed source * unsigned gain

    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE,
        OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [KW-1:0]   k_q, k_d;

    logic signed [DATA_W-1:0] x_q    [CHANNELS][TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic        [GAIN_W-1:0] gain_q [CHANNELS];
    logic signed [F_W-1:0]    f_q    [CHANNELS];
    logic signed [DATA_W-1:0] y_q    [CHANNELS];
    logic                     filter_en_q;
    logic                     mono_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CHANNELS*DATA_W-1:0] dsp_q;
    logic                     overrun_q;

    // Only bits 1:0 of the config word carry meaning.
    logic unused_cfg;
    assign unused_cfg = ^cfg_reg_in[31:2];

    // -----------------------------------------------------------------------
    // MAC datapath
    // -----------------------------------------------------------------------
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic        [PROD_W-1:0] x_ext, coef_ext;
    logic signed [PROD_W-1:0] mac_prod;
    logic signed [ACC_W-1:0]  acc_base, acc_sum, acc_shift;
    logic signed [F_W-1:0]    f_new;
    logic signed [DATA_W-1:0] x_tap0;

    assign x_sel    = x_q[c_q][k_q];
    assign coef_sel = coef_q[k_q];
    assign x_tap0   = x_q[c_q][0];

    // Operands are sign-extended to the product width; the low PROD_W bits
    // of the unsigned product equal the two's-complement signed product.
    assign x_ext    = {{COEF_W{x_sel[DATA_W-1]}}, x_sel};
    assign coef_ext = {{DATA_W{coef_sel[COEF_W-1]}}, coef_sel};
    assign mac_prod = x_ext * coef_ext;

    // Tap 0 starts a fresh sum, so the accumulator never needs clearing.
    assign acc_base  = (k_q == '0) ? '0 : acc_q;
    assign acc_sum   = acc_base + {{KW{mac_prod[PROD_W-1]}}, mac_prod};
    assign acc_shift = acc_sum >>> (COEF_W - 1);

    // Bypass still walks all taps so latency does not depend on the mode.
    assign f_new = filter_en_q ? acc_shift[F_W-1:0]
                               : {{(F_W-DATA_W){x_tap0[DATA_W-1]}}, x_tap0};

    // -----------------------------------------------------------------------
    // Gain / saturation datapath
    // -----------------------------------------------------------------------
    logic signed [F_W-1:0]    f_cur;
    logic signed [SRC_W-1:0]  mono_avg;
    logic                     mono_eff;
    logic signed [SRC_W-1:0]  src;
    logic        [GAIN_W-1:0] gain_sel;
    logic signed [SP_W-1:0]   scale_prod, scale_shift;
    logic [SP_W-DATA_W:0]     scale_top;
    logic                     scale_fits;
    logic signed [DATA_W-1:0] y_new;

    assign f_cur    = f_q[c_q];
    assign gain_sel = gain_q[c_q];

    generate
        if (CHANNELS >= 2) begin : g_mono
            logic signed [SRC_W-1:0] mono_sum;
            assign mono_sum = {f_q[0][F_W-1], f_q[0]} + {f_q[1][F_W-1], f_q[1]};
            assign mono_avg = mono_sum >>> 1;
            assign mono_eff = mono_q;
        end else begin : g_no_mono
            // A single channel has nothing to downmix.
            logic unused_mono;
            assign unused_mono = mono_q;
            assign mono_avg    = {f_q[0][F_W-1], f_q[0]};
            assign mono_eff    = 1'b0;
        end
    endgenerate

    assign src = mono_eff ? mono_avg : {f_cur[F_W-1], f_cur};

    // Gain is unsigned: zero-extend it, sign-extend the source.
    assign scale_prod  = {{(SP_W-SRC_W){src[SRC_W-1]}}, src} *
                         {{(SP_W-GAIN_W){1'b0}}, gain_sel};
    assign scale_shift = scale_prod >>> (GAIN_W - 1);

    // The result fits DATA_W when every bit above the target sign bit
    // matches it; otherwise clamp towards the sign of the wide result.
    assign scale_top  = scale_shift[SP_W-1:DATA_W-1];
    assign scale_fits = (&scale_top) | ~(|scale_top);
    assign y_new = scale_fits            ? scale_shift[DATA_W-1:0] :
                   scale_shift[SP_W-1]   ? {1'b1, {(DATA_W-1){1'b0}}} :
                                           {1'b0, {(DATA_W-1){1'b1}}};

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of all others.
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (tick_in) begin
                    state_d = MAC;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            MAC: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (c_q == C_LAST) begin
                        c_d     = '0;
                        state_d = SCALE;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            SCALE: begin
                if (c_q == C_LAST) begin
                    c_d     = '0;
                    state_d = OUT;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr_in) begin
            state_d = IDLE;
            c_d     = '0;
            k_d     = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Storage and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay lines and coefficient/gain tables are reset on
            // purpose: a muted, zero-history start is part of the contract.
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) x_q[c][k] <= '0;
                gain_q[c] <= '0;
                f_q[c]    <= '0;
                y_q[c]    <= '0;
            end
            for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
            filter_en_q <= 1'b0;
            mono_q      <= 1'b0;
            acc_q       <= '0;
            dsp_q       <= '0;
            overrun_q   <= 1'b0;
        end else if (clr_in) begin
            // Configuration survives a clear; history and outputs do not.
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < TAPS; k++) x_q[c][k] <= '0;
            dsp_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (cfg_in) begin
                    for (int k = 0; k < TAPS; k++)
                        coef_q[k] <= coef_in[k*COEF_W +: COEF_W];
                    filter_en_q <= cfg_reg_in[0];
                    mono_q      <= cfg_reg_in[1];
                end
                if (level_in) begin
                    for (int c = 0; c < CHANNELS; c++)
                        gain_q[c] <= level_reg_in[c*GAIN_W +: GAIN_W];
                end
                if (tick_in) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        for (int k = TAPS - 1; k > 0; k--) x_q[c][k] <= x_q[c][k-1];
                        x_q[c][0] <= abuf_in[c*DATA_W +: DATA_W];
                    end
                end
            end else if (tick_in) begin
                // Dropped sample; the running computation is untouched.
                overrun_q <= 1'b1;
            end

            if (state_q == MAC) begin
                acc_q <= acc_sum;
                if (k_q == K_LAST) f_q[c_q] <= f_new;
            end

            if (state_q == SCALE) begin
                y_q[c_q] <= y_new;
                // The last channel goes straight to the output word so all
                // channels appear together in the OUT cycle.
                if (c_q == C_LAST) begin
                    for (int c = 0; c < CHANNELS; c++)
                        dsp_q[c*DATA_W +: DATA_W] <= (CW'(c) == c_q) ? y_new : y_q[c];
                end
            end
        end
    end

    assign dsp_out     = dsp_q;
    assign valid_out   = (state_q == OUT);
    assign busy_out    = (state_q != IDLE);
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_dsp_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_dsp_unit_mc
//
// Scoreboard bench for dsp_unit_mc at default parameters. Each accepted tick
// pushes the expected output word (from an integer reference model) and the
// tick cycle; each valid_out pulse pops and compares data and latency.
// ---------------------------------------------------------------------------
module tb_dsp_unit_mc;

    localparam int CH  = 2;
    localparam int DW  = 24;
    localparam int TP  = 32;
    localparam int CWD = 32;
    localparam int GW  = 16;
    localparam int LAT = CH * (TP + 1) + 1;

    logic                 clk;
    logic                 rst;
    logic                 tick_in;
    logic                 cfg_in;
    logic                 level_in;
    logic                 clr_in;
    logic [CH*DW-1:0]     abuf_in;
    logic [TP*CWD-1:0]    coef_in;
    logic [CH*GW-1:0]     level_reg_in;
    logic [31:0]          cfg_reg_in;
    logic [CH*DW-1:0]     dsp_out;
    logic                 valid_out;
    logic                 busy_out;
    logic                 overrun_out;

    dsp_unit_mc #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .TAPS     (TP),
        .COEF_W   (CWD),
        .GAIN_W   (GW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .cfg_in       (cfg_in),
        .level_in     (level_in),
        .clr_in       (clr_in),
        .abuf_in      (abuf_in),
        .coef_in      (coef_in),
        .level_reg_in (level_reg_in),
        .cfg_reg_in   (cfg_reg_in),
        .dsp_out      (dsp_out),
        .valid_out    (valid_out),
        .busy_out     (busy_out),
        .overrun_out  (overrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    longint mx    [CH][TP];
    longint mcoef [TP];
    longint mgain [CH];
    bit     mfen;
    bit     mmono;

    typedef struct {
        logic [CH*DW-1:0] dsp;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [CH*DW-1:0] last_dsp = '0;

    function automatic logic [CH*DW-1:0] model_out();
        longint f [CH];
        longint acc, m, y;
        longint ymax = (longint'(1) << (DW - 1)) - 1;
        longint ymin = -(longint'(1) << (DW - 1));
        logic [CH*DW-1:0] r = '0;
        for (int c = 0; c < CH; c++) begin
            if (mfen) begin
                acc = 0;
                for (int k = 0; k < TP; k++) acc += mx[c][k] * mcoef[k];
                f[c] = acc >>> (CWD - 1);
            end else begin
                f[c] = mx[c][0];
            end
        end
        for (int c = 0; c < CH; c++) begin
            m = mmono ? ((f[0] + f[1]) >>> 1) : f[c];
            y = (m * mgain[c]) >>> (GW - 1);
            if (y > ymax) y = ymax;
            if (y < ymin) y = ymin;
            r[c*DW +: DW] = y[DW-1:0];
        end
        return r;
    endfunction

    task automatic model_clear_lines();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < TP; k++) mx[c][k] = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    // Called just after a negedge: drives the tick and records the expectation.
    task automatic drive_tick(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        exp_t e;
        abuf_in = {s1, s0};
        tick_in = 1'b1;
        for (int c = 0; c < CH; c++)
            for (int k = TP - 1; k > 0; k--) mx[c][k] = mx[c][k-1];
        mx[0][0] = longint'($signed(s0));
        mx[1][0] = longint'($signed(s1));
        e.dsp = model_out();
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_tick(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        @(negedge clk);
        drive_tick(s0, s1);
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic apply_cfg(input bit fen, input bit mono, input logic [TP*CWD-1:0] coefs);
        cfg_in     = 1'b1;
        cfg_reg_in = {30'h2AAAAAAA, mono, fen};   // upper bits are don't-care
        coef_in    = coefs;
        mfen       = fen;
        mmono      = mono;
        for (int k = 0; k < TP; k++) mcoef[k] = longint'($signed(coefs[k*CWD +: CWD]));
    endtask

    task automatic load_cfg(input bit fen, input bit mono, input logic [TP*CWD-1:0] coefs);
        @(negedge clk);
        apply_cfg(fen, mono, coefs);
        @(negedge clk);
        cfg_in = 1'b0;
    endtask

    task automatic load_level(input logic [GW-1:0] g0, input logic [GW-1:0] g1);
        @(negedge clk);
        level_in     = 1'b1;
        level_reg_in = {g1, g0};
        mgain[0]     = longint'(g0);
        mgain[1]     = longint'(g1);
        @(negedge clk);
        level_in = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
        model_clear_lines();
        last_dsp = '0;
    endtask

    // Bounded wait for all outstanding results, then confirm the pulse ended.
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        @(negedge clk);
        check("valid_pulse_width", 64'(valid_out), 64'(0));
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(valid_out), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("dsp_ch0", 64'(dsp_out[0*DW +: DW]), 64'(mon_e.dsp[0*DW +: DW]));
                check("dsp_ch1", 64'(dsp_out[1*DW +: DW]), 64'(mon_e.dsp[1*DW +: DW]));
                check("latency", 64'(cyc - mon_e.cyc), 64'(LAT));
                last_dsp = mon_e.dsp;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    logic [TP*CWD-1:0] coefs;

    initial begin
        rst          = 1'b1;
        tick_in      = 1'b0;
        cfg_in       = 1'b0;
        level_in     = 1'b0;
        clr_in       = 1'b0;
        abuf_in      = '0;
        coef_in      = '0;
        level_reg_in = '0;
        cfg_reg_in   = '0;
        mfen  = 1'b0;
        mmono = 1'b0;
        for (int k = 0; k < TP; k++) mcoef[k] = 0;
        for (int c = 0; c < CH; c++) mgain[c] = 0;
        model_clear_lines();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dsp_out",  64'(dsp_out),     64'(0));
        check("rst_valid",    64'(valid_out),   64'(0));
        check("rst_busy",     64'(busy_out),    64'(0));
        check("rst_overrun",  64'(overrun_out), 64'(0));

        // Gain is zero after reset: output muted.
        do_tick(24'h100000, 24'h000000);
        wait_drain();

        // Bypass at unity gain passes samples through unchanged.
        load_level(16'h8000, 16'h8000);
        load_cfg(1'b0, 1'b0, '0);
        do_tick(24'h123456, 24'hFEDCBA);
        wait_drain();
        repeat (5) @(negedge clk);
        check("dsp_hold", 64'(dsp_out), 64'(last_dsp));

        // FIR impulse response: +0.5 at tap 0, -0.5 at tap 3.
        pulse_clr();
        coefs = '0;
        coefs[0*CWD +: CWD] = 32'h40000000;
        coefs[3*CWD +: CWD] = 32'hC0000000;
        load_cfg(1'b1, 1'b0, coefs);
        do_tick(24'h200000, 24'h000000);
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            do_tick(24'h000000, 24'h000000);
            wait_drain();
        end

        // Saturation at both rails.
        coefs = '0;
        coefs[0*CWD +: CWD] = 32'h7FFFFFFF;
        coefs[1*CWD +: CWD] = 32'h7FFFFFFF;
        load_cfg(1'b1, 1'b0, coefs);
        load_level(16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            do_tick(24'h7FFFFF, 24'h7FFFFF);
            wait_drain();
        end
        for (int i = 0; i < 2; i++) begin
            do_tick(24'h800000, 24'h800000);
            wait_drain();
        end

        // Mono downmix in bypass at unity gain.
        load_level(16'h8000, 16'h8000);
        load_cfg(1'b0, 1'b1, '0);
        do_tick(24'h000100, 24'h000300);
        wait_drain();

        // Config strobe coinciding with a tick applies to that sample.
        @(negedge clk);
        apply_cfg(1'b0, 1'b0, '0);
        drive_tick(24'h0ABCDE, 24'hF12345);
        @(negedge clk);
        tick_in = 1'b0;
        cfg_in  = 1'b0;
        wait_drain();

        // Random filtered traffic.
        for (int k = 0; k < TP; k++) coefs[k*CWD +: CWD] = $urandom >> 3;
        coefs[5*CWD +: CWD] = 32'hE0000000 | ($urandom >> 4);
        load_cfg(1'b1, 1'b0, coefs);
        load_level(16'($urandom_range(16'h2000, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 4; i++) begin
            do_tick(24'($urandom), 24'($urandom));
            wait_drain();
        end

        // Tick while busy: dropped, overrun set, level strobe ignored,
        // original result still lands at the original latency.
        do_tick(24'h031415, 24'hFC0DE0);
        repeat (8) @(negedge clk);
        check("busy_mid", 64'(busy_out), 64'(1));
        abuf_in      = {24'h555555, 24'h2AAAAA};
        tick_in      = 1'b1;
        level_in     = 1'b1;
        level_reg_in = '0;
        @(negedge clk);
        tick_in  = 1'b0;
        level_in = 1'b0;
        check("overrun_set", 64'(overrun_out), 64'(1));
        wait_drain();
        check("overrun_sticky", 64'(overrun_out), 64'(1));

        // Clear mid-MAC (with a simultaneous tick that must be ignored).
        do_tick(24'h222222, 24'h333333);
        repeat (20) @(negedge clk);
        clr_in  = 1'b1;
        tick_in = 1'b1;
        @(negedge clk);
        clr_in  = 1'b0;
        tick_in = 1'b0;
        exp_q.delete();
        model_clear_lines();
        last_dsp = '0;
        check("clr_valid",   64'(valid_out),   64'(0));
        check("clr_dsp_out", 64'(dsp_out),     64'(0));
        check("clr_overrun", 64'(overrun_out), 64'(0));
        check("clr_busy",    64'(busy_out),    64'(0));
        repeat (LAT + 20) @(negedge clk);
        check("clr_dsp_hold", 64'(dsp_out), 64'(0));

        // Processing resumes after the clear with a fresh history.
        do_tick(24'h0F0F0F, 24'hF0F0F0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
